utf8_stream_sequencer: RTL and testbench
========================================

# utf8_stream_sequencer

Sequences an external `UTF8Decoder` instance from a valid/ready byte stream and presents decoded code points on a valid/ready output stream. It drives the decoder's registered `reset/allow/finish/byte` inputs, waits out the decoder's two-cycle latency, and re-issues a byte rejected as a continuation so that decoding restarts on it. It also substitutes U+FFFD for errors, terminates streams with `finish` when a sequence is still open, and re-initialises the decoder after every stream.

## Interface
- `ERR_CNT_W`, default 16: width of the saturating error counter.
- `clock` in 1: sole clock; everything on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream byte valid.
- `in_ready` out 1: sequencer accepts byte this cycle.
- `in_byte` in 8: stream byte.
- `in_last` in 1: byte is final byte of stream.
- `dec_reset` out 1: to decoder `reset`.
- `dec_allow` out 1: to decoder `allow`.
- `dec_finish` out 1: to decoder `finish`.
- `dec_byte` out 8: to decoder `byte`.
- `dec_code_point` in 21: from decoder `code_point`.
- `dec_status` in 2: from decoder `status`; 0 INITIAL, 1 INPROCESS, 2 READY, 3 ERROR.
- `out_valid` out 1: code point valid.
- `out_ready` in 1: downstream accepts.
- `out_code_point` out 21: decoded scalar, or 0x00FFFD on error.
- `out_error` out 1: output is an error substitute.
- `out_last` out 1: final output of stream.
- `error_count` out ERR_CNT_W: errors emitted since reset; saturates at all-ones.

## Operation
- All outputs are registered. Reset values: `in_ready`=0, `dec_reset`=1, `dec_allow`=0, `dec_finish`=0, `dec_byte`=0, `out_valid`=0, `out_code_point`=0, `out_error`=0, `out_last`=0, `error_count`=0.
- Internal state: `hold_byte`, `hold_last`, `pending` (last CHECK saw INPROCESS), `reissue`, `fin_cycle`.
- FSM states: DRAIN, IDLE, ISSUE, WAIT, CHECK, EMIT.
- DRAIN: `dec_reset`=1 for exactly 2 cycles via a counter, then IDLE. DRAIN is entered from `reset` and after every EMIT with `out_last`=1. It clears `pending`, `reissue`, and `fin_cycle`.
- IDLE: `in_ready`=1. On `in_valid`, capture `in_byte`/`in_last` into hold, then go to ISSUE.
- ISSUE, one cycle: `dec_allow`=1, `dec_byte`=`hold_byte`, `dec_finish`=`fin_cycle`. Then WAIT, then CHECK.
- CHECK samples `dec_status`:
  - READY: emit `dec_code_point`, `out_error`=0, `out_last`=`hold_last`; clear `pending`.
  - INPROCESS: no output; set `pending`. If `hold_last`, set `fin_cycle` and go to ISSUE; else go to IDLE.
  - ERROR during `fin_cycle`: emit 0xFFFD with `out_error`=1 and `out_last`=1.
  - ERROR with `pending`=1 (continuation rejected): emit 0xFFFD with `out_last`=0 and set `reissue`.
  - ERROR otherwise (invalid lead byte): emit 0xFFFD with `out_last`=`hold_last`.
  - Every ERROR clears `pending`.
  - INITIAL must not occur outside DRAIN. If seen, treat it as ERROR.
- EMIT holds `out_valid` and its data stable until `out_ready`. On the handshake, increment `error_count` if `out_error`. Then:
  - if `reissue`: clear it and go to ISSUE with the same `hold_byte`/`hold_last`;
  - else if `out_last`: go to DRAIN;
  - else go to IDLE.
- A reissued byte is decoded from the ground state, e.g. E2 41 yields FFFD then 0x41.
- `reset` asserted in any state aborts the current state, discards the held byte and any pending output, and enters DRAIN on the following cycle.

## Timing
- The decoder registers its inputs, so a value driven in cycle t yields a status visible in cycle t+2. ISSUE is cycle t, WAIT is t+1, CHECK is t+2.
- Minimum cost per byte with an immediate `out_ready`:
  - IDLE accept, ISSUE, WAIT, CHECK, EMIT: 5 cycles per emitted byte.
  - 4 cycles for a non-final lead or continuation byte (no EMIT).
- From IDLE handshake to `out_valid` for ASCII: 4 cycles.
- `in_ready` is high only in IDLE, so exactly one byte is in flight. `in_valid` with `in_ready` low is ignored.
- The earliest `in_ready` after deassertion of `reset` is 3 cycles: 2 DRAIN cycles plus the transition to IDLE.
- `dec_allow` is high for exactly one cycle per ISSUE.

## Test plan
- Stream 0x41(last) -> one output 0x000041, error=0, last=1, followed by a 2-cycle `dec_reset` pulse.
- Stream F0 9F 98 80(last) -> one output 0x01F600, last=1. No output for the first three bytes.
- Stream E2 41(last) -> FFFD with error=1, last=0; then 0x000041 with last=1. `error_count`=1.
- Stream C3(last) -> finish issued (`dec_finish`=1 for one cycle) -> FFFD with error=1, last=1.
- Stream 0x80, 0x62(last) with `out_ready` held low 10 cycles -> FFFD held stable until accepted, then 0x62 with last=1.
- Assert `reset` for 1 cycle during WAIT of E2 -> no output. The next stream 0x24(last) decodes to 0x000024 with no spurious error.

Source files
------------

// File: rtl/utf8_stream_sequencer.sv
// Feeds a registered UTF-8 decoder one byte at a time from a valid/ready stream and
// re-emits its results as a valid/ready code point stream with U+FFFD substitution.
module utf8_stream_sequencer #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_byte,
    input  logic                 in_last,
    output logic                 dec_reset,
    output logic                 dec_allow,
    output logic                 dec_finish,
    output logic [7:0]           dec_byte,
    input  logic [20:0]          dec_code_point,
    input  logic [1:0]           dec_status,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [20:0]          out_code_point,
    output logic                 out_error,
    output logic                 out_last,
    output logic [ERR_CNT_W-1:0] error_count
);

    // DRAIN reset decoder | IDLE accept byte | ISSUE drive decoder | WAIT latency | CHECK sample status | EMIT hand off
    typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, CHECK, EMIT} state_t;

    localparam logic [1:0]  ST_INPROCESS = 2'd1;
    localparam logic [1:0]  ST_READY     = 2'd2;
    localparam logic [20:0] REPLACEMENT  = 21'h00FFFD;

    state_t     state;
    logic       drain_cnt;
    logic [7:0] hold_byte;
    logic       hold_last;
    logic       pending;
    logic       reissue;
    logic       fin_cycle;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= DRAIN;
            drain_cnt      <= 1'b0;
            hold_byte      <= 8'h00;
            hold_last      <= 1'b0;
            pending        <= 1'b0;
            reissue        <= 1'b0;
            fin_cycle      <= 1'b0;
            in_ready       <= 1'b0;
            dec_reset      <= 1'b1;
            dec_allow      <= 1'b0;
            dec_finish     <= 1'b0;
            dec_byte       <= 8'h00;
            out_valid      <= 1'b0;
            out_code_point <= 21'h0;
            out_error      <= 1'b0;
            out_last       <= 1'b0;
            error_count    <= '0;
        end else begin
            dec_allow  <= 1'b0;
            dec_finish <= 1'b0;
            case (state)
                DRAIN: begin
                    pending   <= 1'b0;
                    reissue   <= 1'b0;
                    fin_cycle <= 1'b0;
                    if (drain_cnt) begin
                        drain_cnt <= 1'b0;
                        dec_reset <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        hold_byte  <= in_byte;
                        hold_last  <= in_last;
                        in_ready   <= 1'b0;
                        dec_allow  <= 1'b1;
                        dec_byte   <= in_byte;
                        dec_finish <= fin_cycle;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT:  state <= CHECK;
                CHECK: begin
                    case (dec_status)
                        ST_READY: begin
                            pending        <= 1'b0;
                            out_valid      <= 1'b1;
                            out_code_point <= dec_code_point;
                            out_error      <= 1'b0;
                            out_last       <= hold_last;
                            state          <= EMIT;
                        end
                        ST_INPROCESS: begin
                            pending <= 1'b1;
                            if (hold_last) begin
                                // stream ended mid-sequence: close it with finish on the same byte
                                fin_cycle  <= 1'b1;
                                dec_allow  <= 1'b1;
                                dec_byte   <= hold_byte;
                                dec_finish <= 1'b1;
                                state      <= ISSUE;
                            end else begin
                                in_ready <= 1'b1;
                                state    <= IDLE;
                            end
                        end
                        default: begin
                            pending        <= 1'b0;
                            out_valid      <= 1'b1;
                            out_code_point <= REPLACEMENT;
                            out_error      <= 1'b1;
                            state          <= EMIT;
                            if (fin_cycle) begin
                                out_last <= 1'b1;
                            end else if (pending) begin
                                out_last <= 1'b0;
                                reissue  <= 1'b1;
                            end else begin
                                out_last <= hold_last;
                            end
                        end
                    endcase
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_error && (error_count != '1)) begin
                            error_count <= error_count + 1'b1;
                        end
                        if (reissue) begin
                            // rejected continuation byte restarts decoding from the ground state
                            reissue    <= 1'b0;
                            dec_allow  <= 1'b1;
                            dec_byte   <= hold_byte;
                            dec_finish <= fin_cycle;
                            state      <= ISSUE;
                        end else if (out_last) begin
                            dec_reset <= 1'b1;
                            drain_cnt <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    dec_reset <= 1'b1;
                    drain_cnt <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= DRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_utf8_stream_sequencer.sv
// Bench for utf8_stream_sequencer: a cycle-level decoder stand-in, a stream-level
// expectation model, and a per-cycle compare process on the output stream.
`timescale 1ns/1ps
module tb_utf8_stream_sequencer;
    localparam int ERR_CNT_W = 16;

    typedef struct packed { logic [20:0] cp; logic err; logic last; } exp_t;
    typedef struct packed { logic [7:0] b; logic last; } in_t;
    typedef logic [7:0] bq_t[$];
    typedef exp_t eq_t[$];

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 in_valid, in_ready, in_last;
    logic [7:0]           in_byte;
    logic                 dec_reset, dec_allow, dec_finish;
    logic [7:0]           dec_byte;
    logic [20:0]          dec_code_point;
    logic [1:0]           dec_status;
    logic                 out_valid, out_ready, out_error, out_last;
    logic [20:0]          out_code_point;
    logic [ERR_CNT_W-1:0] error_count;

    utf8_stream_sequencer #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
        .dec_reset(dec_reset), .dec_allow(dec_allow), .dec_finish(dec_finish), .dec_byte(dec_byte),
        .dec_code_point(dec_code_point), .dec_status(dec_status),
        .out_valid(out_valid), .out_ready(out_ready), .out_code_point(out_code_point),
        .out_error(out_error), .out_last(out_last), .error_count(error_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, valid_cyc = 0, acc_count = 0, fin_total = 0, exp_err_cnt = 0;
    int ready_mode = 0;
    logic gaps = 1'b0;
    in_t  in_q[$];
    exp_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---- decoder stand-in: inputs registered, status visible two cycles after drive
    logic        r_rst = 1'b1, r_allow = 1'b0, r_fin = 1'b0;
    logic [7:0]  r_byte = 8'h00;
    logic [1:0]  d_status = 2'd0;
    logic [20:0] d_cp = 21'h0, d_acc = 21'h0;
    int          d_need = 0;
    assign dec_status     = d_status;
    assign dec_code_point = d_cp;

    always @(posedge clock) begin
        if (r_rst) begin
            d_status <= 2'd0; d_need <= 0; d_acc <= 21'h0; d_cp <= 21'h0;
        end else if (r_allow) begin
            if (r_fin) begin
                if (d_need != 0) d_status <= 2'd3;
                d_need <= 0;
            end else if (d_need == 0) begin
                if (r_byte < 8'h80) begin
                    d_status <= 2'd2; d_cp <= {13'd0, r_byte};
                end else if (r_byte >= 8'hC2 && r_byte <= 8'hDF) begin
                    d_status <= 2'd1; d_need <= 1; d_acc <= {16'd0, r_byte[4:0]};
                end else if (r_byte >= 8'hE0 && r_byte <= 8'hEF) begin
                    d_status <= 2'd1; d_need <= 2; d_acc <= {17'd0, r_byte[3:0]};
                end else if (r_byte >= 8'hF0 && r_byte <= 8'hF4) begin
                    d_status <= 2'd1; d_need <= 3; d_acc <= {18'd0, r_byte[2:0]};
                end else begin
                    d_status <= 2'd3;
                end
            end else if (r_byte[7:6] == 2'b10) begin
                if (d_need == 1) begin
                    d_status <= 2'd2; d_cp <= {d_acc[14:0], r_byte[5:0]};
                end else begin
                    d_status <= 2'd1;
                end
                d_acc  <= {d_acc[14:0], r_byte[5:0]};
                d_need <= d_need - 1;
            end else begin
                d_status <= 2'd3; d_need <= 0;
            end
        end
        r_rst <= dec_reset; r_allow <= dec_allow; r_fin <= dec_finish; r_byte <= dec_byte;
    end

    // ---- stream-level expectation model
    function automatic exp_t mk(input logic [20:0] cp, input logic e, input logic l);
        exp_t x;
        x.cp = cp; x.err = e; x.last = l;
        return x;
    endfunction

    function automatic void model_stream(input bq_t b, output eq_t r);
        int i, need, n;
        logic [20:0] acc;
        logic [7:0]  x;
        logic        lst;
        r = {}; i = 0; need = 0; acc = 21'h0; n = b.size();
        while (i < n) begin
            x = b[i]; lst = (i == n - 1);
            if (need == 0) begin
                i++;
                if (x < 8'h80) r.push_back(mk({13'd0, x}, 1'b0, lst));
                else if (x >= 8'hC2 && x <= 8'hDF) begin need = 1; acc = {16'd0, x[4:0]}; end
                else if (x >= 8'hE0 && x <= 8'hEF) begin need = 2; acc = {17'd0, x[3:0]}; end
                else if (x >= 8'hF0 && x <= 8'hF4) begin need = 3; acc = {18'd0, x[2:0]}; end
                else r.push_back(mk(21'h00FFFD, 1'b1, lst));
            end else if (x[7:6] == 2'b10) begin
                i++; need--;
                acc = {acc[14:0], x[5:0]};
                if (need == 0) r.push_back(mk(acc, 1'b0, lst));
            end else begin
                r.push_back(mk(21'h00FFFD, 1'b1, 1'b0));
                need = 0;
            end
        end
        if (need != 0) r.push_back(mk(21'h00FFFD, 1'b1, 1'b1));
    endfunction

    function automatic logic [7:0] rand_byte();
        int c;
        c = $urandom_range(0, 9);
        if (c <= 2) return 8'($urandom_range(8'h00, 8'h7F));
        if (c == 3) return 8'($urandom_range(8'hC2, 8'hDF));
        if (c == 4) return 8'($urandom_range(8'hE0, 8'hEF));
        if (c == 5) return 8'($urandom_range(8'hF0, 8'hF4));
        if (c <= 8) return 8'($urandom_range(8'h80, 8'hBF));
        if ($urandom_range(0, 1) == 0) return 8'($urandom_range(8'hC0, 8'hC1));
        return 8'($urandom_range(8'hF5, 8'hFF));
    endfunction

    task automatic push_stream(input bq_t b);
        in_t e;
        foreach (b[i]) begin
            e.b = b[i]; e.last = (i == b.size() - 1);
            in_q.push_back(e);
        end
    endtask

    task automatic directed(input string name, input bq_t b, input eq_t lit);
        eq_t m;
        model_stream(b, m);
        check({name, "_model_len"}, 64'(m.size()), 64'(lit.size()));
        foreach (lit[i]) begin
            if (i < m.size()) check({name, "_model"}, 64'(m[i]), 64'(lit[i]));
            exp_q.push_back(lit[i]);
        end
        push_stream(b);
    endtask

    task automatic wait_done(input string name, input int limit);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0 || !in_ready) && k < limit) begin
            @(negedge clock); k++;
        end
        check({name, "_complete"}, 64'(k < limit), 64'(1));
    endtask

    // ---- byte feeder
    initial begin
        logic hs;
        in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
        forever begin
            @(negedge clock);
            hs = in_valid && in_ready && !reset;
            if (hs) begin
                acc_cyc = cyc;
                void'(in_q.pop_front());
                acc_count++;
            end
            @(posedge clock); #1;
            if (hs) in_valid = 1'b0;
            if (!in_valid && in_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                in_byte = in_q[0].b; in_last = in_q[0].last; in_valid = 1'b1;
            end
        end
    end

    // ---- downstream ready
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock); #2;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 2) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---- compare process
    logic prev_stall = 1'b0, prev_allow = 1'b0, prev_valid = 1'b0, rst_in_run = 1'b0;
    exp_t prev_out;
    int   rst_run = 0;
    always @(negedge clock) begin
        if (dec_reset) begin
            rst_run++;
            if (reset) rst_in_run = 1'b1;
        end else if (rst_run > 0) begin
            if (!rst_in_run) check("dec_reset_len", 64'(rst_run), 64'(2));
            rst_run = 0; rst_in_run = 1'b0;
        end
        if (dec_finish) fin_total++;
        if (!reset) begin
            check("error_count", 64'(error_count), 64'(exp_err_cnt));
            if (dec_allow) check("dec_allow_pulse", 64'(prev_allow), 64'(0));
            if (in_ready) check("in_ready_vs_out_valid", 64'(out_valid), 64'(0));
            if (prev_stall)
                check("hold_stable", 64'({out_valid, out_code_point, out_error, out_last}),
                      64'({1'b1, prev_out}));
            if (out_valid && !prev_valid) valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'(0));
            end else if (out_valid && out_ready) begin
                check("out_data", 64'({out_code_point, out_error, out_last}), 64'(exp_q[0]));
                if (exp_q[0].err && exp_err_cnt < 65535) exp_err_cnt++;
                void'(exp_q.pop_front());
            end
        end
        prev_allow = dec_allow;
        prev_valid = out_valid && !reset;
        prev_stall = out_valid && !out_ready && !reset;
        prev_out   = {out_code_point, out_error, out_last};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---- main sequence
    initial begin
        bq_t b;
        eq_t e, m;
        int  f0, c0, k;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state",
              64'({in_ready, dec_reset, dec_allow, dec_finish, dec_byte, out_valid,
                   out_code_point, out_error, out_last, error_count}),
              64'({1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 21'h0, 1'b0, 1'b0, 16'h0}));
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            check("ready_after_reset", 64'(in_ready), 64'(i == 3));
            check("dec_reset_after_reset", 64'(dec_reset), 64'(i != 3));
        end

        // ASCII
        b = {}; b.push_back(8'h41);
        e = {}; e.push_back(mk(21'h000041, 1'b0, 1'b1));
        directed("ascii", b, e);
        wait_done("ascii", 200);
        check("ascii_latency", 64'(valid_cyc - acc_cyc), 64'(4));

        // four-byte emoji
        f0 = fin_total;
        b = {}; b.push_back(8'hF0); b.push_back(8'h9F); b.push_back(8'h98); b.push_back(8'h80);
        e = {}; e.push_back(mk(21'h01F600, 1'b0, 1'b1));
        directed("emoji", b, e);
        wait_done("emoji", 300);
        check("emoji_no_finish", 64'(fin_total - f0), 64'(0));

        // truncated sequence then reissued ASCII
        b = {}; b.push_back(8'hE2); b.push_back(8'h41);
        e = {}; e.push_back(mk(21'h00FFFD, 1'b1, 1'b0)); e.push_back(mk(21'h000041, 1'b0, 1'b1));
        directed("reissue", b, e);
        wait_done("reissue", 300);
        check("reissue_err_cnt", 64'(error_count), 64'(1));

        // open sequence closed by finish
        f0 = fin_total;
        b = {}; b.push_back(8'hC3);
        e = {}; e.push_back(mk(21'h00FFFD, 1'b1, 1'b1));
        directed("finish", b, e);
        wait_done("finish", 300);
        check("finish_pulses", 64'(fin_total - f0), 64'(1));

        // stray continuation with downstream stalled
        ready_mode = 2;
        b = {}; b.push_back(8'h80); b.push_back(8'h62);
        e = {}; e.push_back(mk(21'h00FFFD, 1'b1, 1'b0)); e.push_back(mk(21'h000062, 1'b0, 1'b1));
        directed("stall", b, e);
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clock); k++; end
        check("stall_seen_valid", 64'(out_valid), 64'(1));
        repeat (10) @(negedge clock);
        check("stall_held", 64'({out_valid, out_code_point, out_error}), 64'({1'b1, 21'h00FFFD, 1'b1}));
        ready_mode = 0;
        wait_done("stall", 300);
        check("stall_err_cnt", 64'(error_count), 64'(3));

        // reset during WAIT of an open lead byte
        c0 = acc_count;
        b = {}; b.push_back(8'hE2);
        push_stream(b);
        k = 0;
        while (acc_count == c0 && k < 50) begin @(posedge clock); k++; end
        check("abort_accepted", 64'(acc_count - c0), 64'(1));
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0; exp_err_cnt = 0;
        b = {}; b.push_back(8'h24);
        e = {}; e.push_back(mk(21'h000024, 1'b0, 1'b1));
        directed("after_abort", b, e);
        wait_done("after_abort", 300);
        check("after_abort_err_cnt", 64'(error_count), 64'(0));

        // randomized streams
        for (int s = 0; s < 40; s++) begin
            ready_mode = $urandom_range(0, 1);
            gaps = 1'($urandom_range(0, 1));
            for (int t = 0; t < 4; t++) begin
                b = {};
                for (int j = 0; j < $urandom_range(1, 5); j++) b.push_back(rand_byte());
                model_stream(b, m);
                foreach (m[i]) exp_q.push_back(m[i]);
                push_stream(b);
            end
            wait_done("random", 3000);
        end

        ready_mode = 0;
        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
